nr_multicycle_control: RTL

Parametrised multi-cycle control unit for the nanoRisk core. It replaces single-cycle opcode decoding with an FSM that sequences FETCH/DECODE/EXEC/MEM/WB. It adds a memory ready/wait handshake with timeout, sleep with interrupt wake, and a sticky fault on illegal opcodes. It sits between the instruction register and the datapath: it drives the register bank, ALU, I/O mux and PC-enable.

---
 rtl/nr_multicycle_control.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/nr_multicycle_control.sv
// Multi-cycle control unit for the nanoRisk core.
// Sequences FETCH/DECODE/EXEC/MEM/WB with a memory wait timeout, sleep/wake and a sticky fault.
module nr_multicycle_control #(
    parameter int OPW         = 4,
    parameter int ALU_OPW     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OPW-1:0]     inst_i,
    input  logic               inst_valid_i,
    input  logic               mem_ready_i,
    input  logic               irq_i,
    output logic               ir_ld_o,
    output logic               pc_en_o,
    output logic               tmpwr_o,
    output logic               hlt_o,
    output logic               jmp_o,
    output logic               brc_o,
    output logic [1:0]         rgw_o,
    output logic [3:0]         ioc_o,
    output logic               rgr_o,
    output logic [ALU_OPW-1:0] alo_o,
    output logic               ala_o,
    output logic               busy_o,
    output logic               fault_o,
    output logic [2:0]         state_o
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_SLEEP  = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_fetch_q, to_fetch_d;
    logic          ir_ld_q, ir_ld_d, pc_en_q, pc_en_d, tmpwr_q, tmpwr_d;
    logic          hlt_q, hlt_d, busy_q, busy_d, fault_q, fault_d;
    logic          jmp_q, jmp_d, brc_q, brc_d, rgr_q, rgr_d, ala_q, ala_d;
    logic [1:0]    rgw_q, rgw_d;
    logic [3:0]    ioc_q, ioc_d, alo_q, alo_d;

    logic [OPW+3:0] inst_ext;
    logic           illegal;
    logic [3:0]     op4;

    assign inst_ext = {4'b0000, inst_i};
    assign illegal  = |inst_ext[OPW+3:4];
    assign op4      = inst_i[3:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        to_fetch_d = to_fetch_q;
        ir_ld_d    = 1'b0;
        pc_en_d    = 1'b0;
        tmpwr_d    = 1'b0;
        jmp_d      = jmp_q;
        brc_d      = brc_q;
        rgw_d      = rgw_q;
        ioc_d      = ioc_q;
        rgr_d      = rgr_q;
        alo_d      = alo_q;
        ala_d      = ala_q;
        unique case (state_q)
            S_FETCH: if (inst_valid_i) begin
                ir_ld_d = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                {jmp_d, brc_d, rgw_d, ioc_d, rgr_d, alo_d, ala_d} = '0;
                to_fetch_d = 1'b0;
                state_d    = S_EXEC;
                if (illegal) begin
                    state_d = S_FAULT;
                end else begin
                    unique case (op4)
                        4'h0: begin ioc_d = 4'b0100; state_d = S_SLEEP; end
                        4'h1: begin brc_d = 1'b1; alo_d = 4'b0001; ioc_d = 4'b0100; to_fetch_d = 1'b1; end
                        4'h2: begin brc_d = 1'b1; alo_d = 4'b0010; ioc_d = 4'b1100; end
                        4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                            rgr_d = 1'b1;
                            ioc_d = 4'b1100;
                            unique case (op4)
                                4'h3:    alo_d = 4'b0000;
                                4'h4:    alo_d = 4'b0001;
                                4'h5:    alo_d = 4'b0011;
                                4'h6:    alo_d = 4'b0100;
                                4'h7:    alo_d = 4'b0101;
                                4'h8:    alo_d = 4'b0110;
                                4'h9:    alo_d = 4'b1000;
                                default: alo_d = 4'b0111;
                            endcase
                        end
                        4'hB: begin jmp_d = 1'b1; rgw_d = 2'b01; ioc_d = 4'b1100; to_fetch_d = 1'b1; end
                        4'hC, 4'hD: begin rgw_d = 2'b11; ioc_d = 4'b1000; end
                        4'hE: begin rgw_d = 2'b10; ioc_d = 4'b1101; ala_d = 1'b1; state_d = S_MEM; end
                        default: begin ioc_d = 4'b0110; ala_d = 1'b1; to_fetch_d = 1'b1; state_d = S_MEM; end
                    endcase
                end
                // Short paths finish in EXEC, so their PC pulse is armed here.
                if (state_d == S_EXEC && to_fetch_d) pc_en_d = 1'b1;
            end
            S_EXEC: begin
                if (to_fetch_q) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                    tmpwr_d = 1'b1;
                    pc_en_d = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    cnt_d   = '0;
                    pc_en_d = 1'b1;
                    if (to_fetch_q) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                        tmpwr_d = 1'b1;
                    end
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_SLEEP: if (irq_i) begin
                state_d = S_FETCH;
                pc_en_d = 1'b1;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
        if (state_d == S_FETCH || state_d == S_FAULT) begin
            {jmp_d, brc_d, rgw_d, ioc_d, rgr_d, alo_d, ala_d} = '0;
            to_fetch_d = 1'b0;
        end
        fault_d = fault_q | (state_d == S_FAULT);
        hlt_d   = !(state_d == S_SLEEP || state_d == S_FAULT);
        busy_d  = !(state_d == S_FETCH || state_d == S_SLEEP || state_d == S_FAULT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            to_fetch_q <= 1'b0;
            ir_ld_q    <= 1'b0;
            pc_en_q    <= 1'b0;
            tmpwr_q    <= 1'b0;
            hlt_q      <= 1'b1;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            jmp_q      <= 1'b0;
            brc_q      <= 1'b0;
            rgw_q      <= '0;
            ioc_q      <= '0;
            rgr_q      <= 1'b0;
            alo_q      <= '0;
            ala_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            to_fetch_q <= to_fetch_d;
            ir_ld_q    <= ir_ld_d;
            pc_en_q    <= pc_en_d;
            tmpwr_q    <= tmpwr_d;
            hlt_q      <= hlt_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            jmp_q      <= jmp_d;
            brc_q      <= brc_d;
            rgw_q      <= rgw_d;
            ioc_q      <= ioc_d;
            rgr_q      <= rgr_d;
            alo_q      <= alo_d;
            ala_q      <= ala_d;
        end
    end

    assign state_o = state_q;
    assign ir_ld_o = ir_ld_q;
    assign pc_en_o = pc_en_q;
    assign tmpwr_o = tmpwr_q;
    assign hlt_o   = hlt_q;
    assign busy_o  = busy_q;
    assign fault_o = fault_q;
    assign jmp_o   = jmp_q;
    assign brc_o   = brc_q;
    assign rgw_o   = rgw_q;
    assign ioc_o   = ioc_q;
    assign rgr_o   = rgr_q;
    assign alo_o   = ALU_OPW'(alo_q);
    assign ala_o   = ala_q;

endmodule
